// File: rtl/bidir_pin_responder.sv
// Half-duplex single-wire 8N1 responder for an ECP5 bidirectional pad.
// Receives one byte, waits a fixed turnaround, then optionally drives a response byte.
module bidir_pin_responder #(
    parameter int unsigned BIT_CYCLES  = 16,
    parameter int unsigned TURN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_I,
    output logic       pin_O,
    output logic       pin_T,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic       busy
);

    localparam int unsigned CntMax = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES + 1;
    localparam int unsigned CntW   = $clog2(CntMax);

    localparam logic [CntW-1:0] HalfBitLoad = CntW'(BIT_CYCLES / 2 - 1);
    localparam logic [CntW-1:0] BitLoad     = CntW'(BIT_CYCLES - 1);
    // TURN spans TURN_CYCLES+1 cycles so tx_ack lands TURN_CYCLES+1 cycles after rx_valid.
    localparam logic [CntW-1:0] TurnLoad    = CntW'(TURN_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StRxStart,
        StRxData,
        StRxStop,
        StTurn,
        StTxStart,
        StTxData,
        StTxStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      rx_sr_q, rx_sr_d;
    logic [7:0]      tx_sr_q, tx_sr_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            tx_ack_q, tx_ack_d;
    logic            pin_o_q, pin_o_d;
    logic            pin_t_q, pin_t_d;

    logic sync1_q, sync2_q, s_prev_q;
    logic s_in;
    logic cnt_zero;

    assign s_in     = sync2_q;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            s_prev_q <= 1'b1;
        end else begin
            sync1_q  <= pin_I;
            sync2_q  <= sync1_q;
            s_prev_q <= sync2_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        tx_ack_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (s_prev_q && !s_in) begin
                    state_d = StRxStart;
                    cnt_d   = HalfBitLoad;
                end
            end
            StRxStart: begin
                if (cnt_zero) begin
                    if (!s_in) begin
                        state_d = StRxData;
                        cnt_d   = BitLoad;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRxData: begin
                if (cnt_zero) begin
                    rx_sr_d = {s_in, rx_sr_q[7:1]};
                    cnt_d   = BitLoad;
                    if (bit_q == 3'd7) begin
                        state_d = StRxStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRxStop: begin
                if (cnt_zero) begin
                    if (s_in) begin
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        cnt_d      = TurnLoad;
                        state_d    = StTurn;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTurn: begin
                if (cnt_zero) begin
                    if (tx_valid) begin
                        tx_sr_d  = tx_data;
                        tx_ack_d = 1'b1;
                        cnt_d    = BitLoad;
                        state_d  = StTxStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTxStart: begin
                if (cnt_zero) begin
                    cnt_d   = BitLoad;
                    bit_d   = 3'd0;
                    state_d = StTxData;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTxData: begin
                if (cnt_zero) begin
                    cnt_d   = BitLoad;
                    tx_sr_d = {1'b0, tx_sr_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StTxStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTxStop: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pad controls are computed from the next state so they can be registered.
        pin_t_d = 1'b1;
        pin_o_d = 1'b1;
        unique case (state_d)
            StTxStart: begin
                pin_t_d = 1'b0;
                pin_o_d = 1'b0;
            end
            StTxData: begin
                pin_t_d = 1'b0;
                pin_o_d = tx_sr_d[0];
            end
            StTxStop: begin
                pin_t_d = 1'b0;
                pin_o_d = 1'b1;
            end
            default: begin
                pin_t_d = 1'b1;
                pin_o_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            rx_sr_q     <= 8'h00;
            tx_sr_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ack_q    <= 1'b0;
            pin_o_q     <= 1'b1;
            pin_t_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            tx_ack_q    <= tx_ack_d;
            pin_o_q     <= pin_o_d;
            pin_t_q     <= pin_t_d;
        end
    end

    assign pin_O     = pin_o_q;
    assign pin_T     = pin_t_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign tx_ack    = tx_ack_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bidir_pin_responder.sv
// Bench for bidir_pin_responder: table of frames driven on a modelled pad, events
// checked against a scoreboard queue, plus glitch and mid-transmit reset sequences.
module tb_bidir_pin_responder;

    localparam int BC   = 16;
    localparam int TURN = 4;

    localparam int EvRx   = 0;
    localparam int EvFerr = 1;
    localparam int EvTx   = 2;

    logic       clk;
    logic       rst;
    logic       ext;
    logic       pin_in;
    logic       pin_O;
    logic       pin_T;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ack;
    logic       busy;

    // Pad model: the DUT wins when it drives, otherwise the initiator (pull-up idle).
    assign pin_in = pin_T ? ext : pin_O;

    bidir_pin_responder #(
        .BIT_CYCLES  (BC),
        .TURN_CYCLES (TURN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pin_I     (pin_in),
        .pin_O     (pin_O),
        .pin_T     (pin_T),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ack    (tx_ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         len;
        logic       ok;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       txv;
        logic [7:0] txd;
    } vec_t;

    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] last_rx = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic got_event(input int kind, input logic [7:0] data, input int len,
                             input logic ok);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", kind, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_data", data, e.data);
            if (kind == EvTx) begin
                check("tx_drive_len", len, e.len);
                check("tx_framing", ok, e.ok);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    int         cyc = 0;
    int         rxv_cyc = 0;
    logic       rxv_p = 1'b0, fe_p = 1'b0, ack_p = 1'b0;
    int         tx_len = 0;
    logic [9:0] tx_bits = '0;
    logic       tx_unstable = 1'b0;
    logic       bit_first = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            tx_len      = 0;
            tx_unstable = 1'b0;
            rxv_p       = 1'b0;
            fe_p        = 1'b0;
            ack_p       = 1'b0;
        end else begin
            if (rx_valid) begin
                check("rx_valid_width", rxv_p, 1'b0);
                rxv_cyc = cyc;
                got_event(EvRx, rx_data, 0, 1'b1);
            end
            if (frame_err) begin
                check("frame_err_width", fe_p, 1'b0);
                check("frame_err_without_rx_valid", rx_valid, 1'b0);
                got_event(EvFerr, rx_data, 0, 1'b1);
            end
            if (tx_ack) begin
                check("tx_ack_width", ack_p, 1'b0);
                check("tx_ack_delay", cyc - rxv_cyc, TURN + 1);
                check("drive_with_tx_ack", pin_T, 1'b0);
            end
            if (!pin_T) begin
                if (tx_len / BC < 10) begin
                    if (tx_len % BC == 1) bit_first = pin_O;
                    if (tx_len % BC == BC / 2) tx_bits[tx_len / BC] = pin_O;
                    if (tx_len % BC == BC - 2 && pin_O !== bit_first) tx_unstable = 1'b1;
                end
                tx_len++;
            end else if (tx_len != 0) begin
                got_event(EvTx, tx_bits[8:1], tx_len,
                          (tx_bits[0] == 1'b0) && (tx_bits[9] == 1'b1) && !tx_unstable);
                tx_len      = 0;
                tx_unstable = 1'b0;
            end
            rxv_p = rx_valid;
            fe_p  = frame_err;
            ack_p = tx_ack;
        end
    end

    task automatic push_ev(input int kind, input logic [7:0] data, input int len);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.len  = len;
        e.ok   = 1'b1;
        exp_q.push_back(e);
    endtask

    // Drives one 8N1 frame; expectations are queued as the stimulus goes out.
    task automatic send_frame(input logic [7:0] data, input logic stop_ok, input logic exp_tx,
                              input logic [7:0] txd);
        logic [9:0] bits;
        bits = {stop_ok, data, 1'b0};
        if (stop_ok) begin
            push_ev(EvRx, data, 0);
            last_rx = data;
        end else begin
            push_ev(EvFerr, last_rx, 0);
        end
        if (exp_tx) push_ev(EvTx, txd, 10 * BC);
        for (int b = 0; b < 10; b++) begin
            ext = bits[b];
            repeat (BC) @(posedge clk);
            #1;
        end
        ext = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy && pin_T) done = 1'b1;
        end
        check("idle_within_bound", done, 1'b1);
    endtask

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_busy;
        logic got;

        vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, txv: 1'b1, txd: 8'h3C};
        vecs[1] = '{data: 8'h55, stop_ok: 1'b0, txv: 1'b1, txd: 8'hAA};
        vecs[2] = '{data: 8'h81, stop_ok: 1'b1, txv: 1'b0, txd: 8'h00};
        vecs[3] = '{data: 8'h7E, stop_ok: 1'b1, txv: 1'b1, txd: 8'hC3};
        vecs[4] = '{data: 8'h00, stop_ok: 1'b1, txv: 1'b1, txd: 8'hFF};
        vecs[5] = '{data: 8'hFF, stop_ok: 1'b1, txv: 1'b1, txd: 8'h01};

        rst      = 1'b1;
        ext      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pin_T", pin_T, 1'b1);
        check("reset_pin_O", pin_O, 1'b1);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_tx_ack", tx_ack, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_reset_busy", busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            tx_valid = vecs[i].txv;
            tx_data  = vecs[i].txd;
            send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].txv && vecs[i].stop_ok,
                       vecs[i].txd);
            wait_idle(400);
            repeat (5) @(posedge clk);
            #1;
        end

        // Short low glitch must be rejected at the start-bit centre.
        tx_valid  = 1'b0;
        seen_busy = 1'b0;
        ext       = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ext = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (busy) seen_busy = 1'b1;
            if (!busy && seen_busy) got = 1'b1;
            if (!pin_T) check("glitch_pin_T", pin_T, 1'b1);
        end
        check("glitch_started_rx", seen_busy, 1'b1);
        check("glitch_back_idle", got, 1'b1);
        check("glitch_busy", busy, 1'b0);

        // Reset landing 50 cycles into the data phase of a response.
        tx_valid = 1'b1;
        tx_data  = 8'h99;
        send_frame(8'h5A, 1'b1, 1'b0, 8'h00);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #1;
            if (tx_len >= BC + 50) got = 1'b1;
        end
        check("reached_tx_data_phase", got, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_pin_T", pin_T, 1'b1);
        check("async_reset_pin_O", pin_O, 1'b1);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_tx_ack", tx_ack, 1'b0);
        check("async_reset_rx_data", rx_data, 8'h00);
        last_rx = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send_frame(8'h12, 1'b1, 1'b0, 8'h00);
        wait_idle(400);
        check("post_reset_rx_data", rx_data, 8'h12);

        repeat (20) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
